// File: rtl/demux_tdm_driver_if.sv
// demux_tdm_driver_if
//   Frame-in / serial-out bundle for the TDM driver that feeds the 1-to-4 demux.
//   master : frame source (drives in_valid, din, ch_mask; observes the rest)
//   slave  : demux_tdm_driver (accepts frames, drives in_ready, s0, s1, x,
//            frame_active, done)
//   Signals:
//     in_valid      frame offered on din/ch_mask
//     in_ready      driver can accept a frame this cycle
//     din[4W]       channel words {d,c,b,a}, a in the low WIDTH bits
//     ch_mask[4]    per-channel enable, bit0=a .. bit3=d
//     s0, s1        demux select {MSB, LSB} = index of channel on x
//     x             serial data, MSB first
//     frame_active  x carries a valid frame bit this cycle
//     done          one-cycle pulse after the last frame bit
interface demux_tdm_driver_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] din;
  logic [3:0]         ch_mask;
  logic               s0;
  logic               s1;
  logic               x;
  logic               frame_active;
  logic               done;

  modport master (
    output in_valid, din, ch_mask,
    input  in_ready, s0, s1, x, frame_active, done
  );

  modport slave (
    input  in_valid, din, ch_mask,
    output in_ready, s0, s1, x, frame_active, done
  );
endinterface

// File: rtl/demux_tdm_driver.sv
// demux_tdm_driver
//   Upstream stage of the 1-to-4 demultiplexer. Captures four WIDTH-bit channel
//   words per frame and serialises the enabled ones onto x, MSB first, in the
//   order a, b, c, d. {s0,s1} carries the index of the channel currently on x.
//   Masked channels take no cycles; an all-zero mask just pulses done.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset (aborts a frame, no done pulse)
//     bus   demux_tdm_driver_if.slave (see interface file for signal list)
//   Optional build macro:
//     PARITY_EN  append one even-parity bit (^word) after each channel's LSB,
//                same select, frame_active high.
//   All outputs are registered; in_ready is high exactly when the FSM is IDLE.
module demux_tdm_driver #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  demux_tdm_driver_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    BIT_TOP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_W   = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [4*WIDTH-1:0] word_q,  word_d;
  logic [3:0]         mask_q,  mask_d;
  logic [1:0]         ch_q,    ch_d;
  logic [CW-1:0]      bit_q,   bit_d;
  logic               x_q,     x_d;
  logic               fa_q,    fa_d;
  logic               done_q,  done_d;
  logic               rdy_q,   rdy_d;
`ifdef PARITY_EN
  logic               par_q,   par_d;
`endif

  logic               lo_found;
  logic [1:0]         lo_ch;
  logic               nxt_found;
  logic [1:0]         nxt_ch;
  logic [WIDTH-1:0]   cur_word;
  logic [CW-1:0]      bit_dec;

  function automatic logic [WIDTH-1:0] pick(input logic [4*WIDTH-1:0] w,
                                            input logic [1:0]         c);
    logic [WIDTH-1:0] r;
    r = '0;
    case (c)
      2'd0: r = w[WIDTH-1:0];
      2'd1: r = w[2*WIDTH-1:WIDTH];
      2'd2: r = w[3*WIDTH-1:2*WIDTH];
      2'd3: r = w[4*WIDTH-1:3*WIDTH];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Lowest enabled channel of the offered frame.
  always_comb begin
    lo_found = 1'b0;
    lo_ch    = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!lo_found && bus.ch_mask[i]) begin
        lo_found = 1'b1;
        lo_ch    = 2'(i);
      end
    end
  end

  // Next enabled channel above the one currently being shifted.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!nxt_found && mask_q[i] && (2'(i) > ch_q)) begin
        nxt_found = 1'b1;
        nxt_ch    = 2'(i);
      end
    end
  end

  assign cur_word = pick(word_q, ch_q);
  assign bit_dec  = bit_q - 1'b1;

  // The output registers are loaded with the bit that will be on x next cycle,
  // so bit_q always names the bit currently visible on x.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    x_d     = 1'b0;
    fa_d    = 1'b0;
    done_d  = 1'b0;
    rdy_d   = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (bus.in_valid && rdy_q) begin
          word_d = bus.din;
          mask_d = bus.ch_mask;
          if (lo_found) begin
            state_d = SHIFT;
            ch_d    = lo_ch;
            bit_d   = BIT_TOP;
            x_d     = |(pick(bus.din, lo_ch) & MSB_W);
            fa_d    = 1'b1;
            rdy_d   = 1'b0;
`ifdef PARITY_EN
            par_d   = 1'b0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        fa_d = 1'b1;
        if (bit_q != '0) begin
          bit_d = bit_dec;
          x_d   = |(cur_word & (ONE_W << bit_dec));
        end
`ifdef PARITY_EN
        else if (!par_q) begin
          par_d = 1'b1;
          x_d   = ^cur_word;
        end
`endif
        else begin
`ifdef PARITY_EN
          par_d = 1'b0;
`endif
          if (nxt_found) begin
            ch_d  = nxt_ch;
            bit_d = BIT_TOP;
            x_d   = |(pick(word_q, nxt_ch) & MSB_W);
          end else begin
            state_d = IDLE;
            fa_d    = 1'b0;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      mask_q <= '0;
      ch_q   <= '0;
      bit_q  <= '0;
      x_q    <= 1'b0;
      fa_q   <= 1'b0;
      done_q <= 1'b0;
      rdy_q  <= 1'b1;
`ifdef PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      ch_q   <= ch_d;
      bit_q  <= bit_d;
      x_q    <= x_d;
      fa_q   <= fa_d;
      done_q <= done_d;
      rdy_q  <= rdy_d;
`ifdef PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  // ch_q is only rewritten on a new channel, so select holds while idle.
  assign bus.s0           = ch_q[1];
  assign bus.s1           = ch_q[0];
  assign bus.x            = x_q;
  assign bus.frame_active = fa_q;
  assign bus.done         = done_q;
  assign bus.in_ready     = rdy_q;

endmodule

// File: tb/tb_demux_tdm_driver.sv
module tb_demux_tdm_driver;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int LPC = W + 1;
`else
  localparam int LPC = W;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [1:0] prev_sel;

  demux_tdm_driver_if #(.WIDTH(W)) bus ();

  demux_tdm_driver #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   mask;
    logic [31:0]  din;
    int           len;
    logic [63:0]  ex;
    logic [127:0] es;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic [1:0] es;
    v = vecs[idx];
    @(negedge clk);
    chk($sformatf("v%0d_rdy_pre", idx), 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.din      = v.din;
    bus.ch_mask  = v.mask;
    for (int k = 0; k < v.len; k++) begin
      @(negedge clk);
      es = v.es[2*(v.len-1-k) +: 2];
      chk($sformatf("v%0d_x_c%0d", idx, k+1), 64'(bus.x), 64'(v.ex[v.len-1-k]));
      chk($sformatf("v%0d_sel_c%0d", idx, k+1), 64'({bus.s0, bus.s1}), 64'(es));
      chk($sformatf("v%0d_fa_c%0d", idx, k+1), 64'(bus.frame_active), 64'd1);
      chk($sformatf("v%0d_done_c%0d", idx, k+1), 64'(bus.done), 64'd0);
      chk($sformatf("v%0d_rdy_c%0d", idx, k+1), 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b0;
      bus.din      = $urandom;
    end
    if (v.len > 0) prev_sel = v.es[1:0];
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), 64'(bus.done), 64'd1);
    chk($sformatf("v%0d_fa_end", idx), 64'(bus.frame_active), 64'd0);
    chk($sformatf("v%0d_x_end", idx), 64'(bus.x), 64'd0);
    chk($sformatf("v%0d_rdy_end", idx), 64'(bus.in_ready), 64'd1);
    chk($sformatf("v%0d_sel_end", idx), 64'({bus.s0, bus.s1}), 64'(prev_sel));
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_drop", idx), 64'(bus.done), 64'd0);
    chk($sformatf("v%0d_fa_idle", idx), 64'(bus.frame_active), 64'd0);
    chk($sformatf("v%0d_sel_hold", idx), 64'({bus.s0, bus.s1}), 64'(prev_sel));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    logic seen_fa;
    logic [7:0] bb;
    logic eb;

    checks   = 0;
    failures = 0;
    prev_sel = 2'b00;

`ifdef PARITY_EN
    vecs[0] = '{4'b0001, 32'h00000007, 9,  64'({8'h07, 1'b1}), 128'({9{2'b00}})};
    vecs[1] = '{4'b1010, 32'h7EFF8133, 18, 64'({8'h81, 1'b0, 8'h7E, 1'b0}),
                128'({{9{2'b01}}, {9{2'b11}}})};
    vecs[2] = '{4'b0000, 32'hDEADBEEF, 0,  64'h0, 128'h0};
    vecs[3] = '{4'b0100, 32'h00F10000, 9,  64'({8'hF1, 1'b1}), 128'({9{2'b10}})};
    vecs[4] = '{4'b0001, 32'h000000A5, 9,  64'({8'hA5, 1'b0}), 128'({9{2'b00}})};
`else
    vecs[0] = '{4'b0001, 32'h000000A5, 8,  64'hA5, 128'h0};
    vecs[1] = '{4'b1010, 32'h7EFF8133, 16, 64'h817E, 128'({{8{2'b01}}, {8{2'b11}}})};
    vecs[2] = '{4'b0000, 32'hDEADBEEF, 0,  64'h0, 128'h0};
    vecs[3] = '{4'b1111, 32'hC35A0180, 32, 64'h80015AC3,
                128'({{8{2'b00}}, {8{2'b01}}, {8{2'b10}}, {8{2'b11}}})};
    vecs[4] = '{4'b0100, 32'h00F00000, 8,  64'hF0, 128'({8{2'b10}})};
`endif

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.din      = '0;
    bus.ch_mask  = '0;
    @(negedge clk);
    chk("rst_x",    64'(bus.x), 64'd0);
    chk("rst_sel",  64'({bus.s0, bus.s1}), 64'd0);
    chk("rst_fa",   64'(bus.frame_active), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rdy",  64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset asserted in cycle 5 of a frame.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din      = 32'h12345678;
    bus.ch_mask  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("mid_fa_before", 64'(bus.frame_active), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_x",    64'(bus.x), 64'd0);
    chk("mid_rst_sel",  64'({bus.s0, bus.s1}), 64'd0);
    chk("mid_rst_fa",   64'(bus.frame_active), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_rdy",  64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    prev_sel = 2'b00;
    seen_done = 1'b0;
    seen_fa   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen_done |= bus.done;
      seen_fa   |= bus.frame_active;
    end
    chk("mid_rst_no_done", 64'(seen_done), 64'd0);
    chk("mid_rst_no_fa",   64'(seen_fa), 64'd0);

    // in_valid held high with changing data; next frame taken in the done cycle.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din      = 32'h000000A5;
    bus.ch_mask  = 4'b0001;
    bb = 8'hA5;
    for (int k = 0; k < LPC; k++) begin
      @(negedge clk);
      eb = (k < W) ? bb[7-k] : ^bb;
      chk($sformatf("hold_x_c%0d", k+1), 64'(bus.x), 64'(eb));
      chk($sformatf("hold_sel_c%0d", k+1), 64'({bus.s0, bus.s1}), 64'd0);
      chk($sformatf("hold_rdy_c%0d", k+1), 64'(bus.in_ready), 64'd0);
      bus.din     = $urandom;
      bus.ch_mask = 4'($urandom);
    end
    @(negedge clk);
    chk("hold_done",   64'(bus.done), 64'd1);
    chk("hold_rdy",    64'(bus.in_ready), 64'd1);
    chk("hold_fa_gap", 64'(bus.frame_active), 64'd0);
    bus.din     = 32'h00003C00;
    bus.ch_mask = 4'b0010;
    bb = 8'h3C;
    for (int k = 0; k < LPC; k++) begin
      @(negedge clk);
      eb = (k < W) ? bb[7-k] : ^bb;
      chk($sformatf("hold2_x_c%0d", k+1), 64'(bus.x), 64'(eb));
      chk($sformatf("hold2_sel_c%0d", k+1), 64'({bus.s0, bus.s1}), 64'd1);
      chk($sformatf("hold2_fa_c%0d", k+1), 64'(bus.frame_active), 64'd1);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("hold2_done", 64'(bus.done), 64'd1);
    chk("hold2_sel",  64'({bus.s0, bus.s1}), 64'd1);
    @(negedge clk);
    chk("hold2_done_drop", 64'(bus.done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
